// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the nickel/dime sensors,
// issues one single-cycle coin code per coin and flags jams.
//
// state | meaning
// IDLE  | waiting for a clean rise on exactly one sensor
// BUSY  | coin issued, waiting for both sensors to release
// JAM   | simultaneous or stuck sensors, codes suppressed until both release
module coin_acceptor #(
    parameter int DEBOUNCE = 4,
    parameter int HOLD_MAX = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    output logic [1:0] coin,
    output logic       jam,
    output logic [7:0] accepted_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, JAM} state_t;

    localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

    // bit 0 = nickel, bit 1 = dime
    logic [1:0] sync1, sync2, filt, filt_d, rise;
    logic [7:0] dcnt [2];

    state_t      state;
    logic [15:0] hold;
    logic        cur_dime;
    logic        other_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 2'b00;
            sync2   <= 2'b00;
            filt    <= 2'b00;
            filt_d  <= 2'b00;
            dcnt[0] <= 8'd0;
            dcnt[1] <= 8'd0;
        end else begin
            sync1  <= {dime_raw, nickel_raw};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    dcnt[i] <= 8'd0;
                end else if (dcnt[i] == DB_LAST) begin
                    filt[i] <= ~filt[i];
                    dcnt[i] <= 8'd0;
                end else begin
                    dcnt[i] <= dcnt[i] + 8'd1;
                end
            end
        end
    end

    assign rise       = filt & ~filt_d;
    assign other_rise = cur_dime ? rise[0] : rise[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            coin         <= 2'b00;
            jam          <= 1'b0;
            accepted_cnt <= 8'd0;
            hold         <= 16'd0;
            cur_dime     <= 1'b0;
        end else begin
            coin <= 2'b00;
            case (state)
                IDLE: begin
                    hold <= 16'd0;
                    // a rise while the other line is already (or also) high is a jam
                    if ((rise[0] && filt[1]) || (rise[1] && filt[0])) begin
                        state <= JAM;
                        jam   <= 1'b1;
                    end else if (rise[0]) begin
                        coin         <= 2'b01;
                        accepted_cnt <= accepted_cnt + 8'd1;
                        cur_dime     <= 1'b0;
                        state        <= BUSY;
                    end else if (rise[1]) begin
                        coin         <= 2'b10;
                        accepted_cnt <= accepted_cnt + 8'd1;
                        cur_dime     <= 1'b1;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (hold != 16'hFFFF) hold <= hold + 16'd1;
                    if (filt == 2'b00) begin
                        state <= IDLE;
                    end else if (other_rise || hold == HOLD_LAST) begin
                        state <= JAM;
                        jam   <= 1'b1;
                    end
                end
                JAM: begin
                    if (filt == 2'b00) begin
                        state <= IDLE;
                        jam   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    jam   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a vector table of single pulses plus
// hand-written bounce, stuck-coin, reset and wrap-around sequences.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst, nickel_raw, dime_raw;
    logic [1:0] coin, coin_h;
    logic       jam, jam_h;
    logic [7:0] accepted_cnt, accepted_cnt_h;

    int total = 0;
    int bad   = 0;

    coin_acceptor dut (
        .clk(clk), .rst(rst), .nickel_raw(nickel_raw), .dime_raw(dime_raw),
        .coin(coin), .jam(jam), .accepted_cnt(accepted_cnt)
    );

    coin_acceptor #(.DEBOUNCE(4), .HOLD_MAX(16)) dut_h (
        .clk(clk), .rst(rst), .nickel_raw(nickel_raw), .dime_raw(dime_raw),
        .coin(coin_h), .jam(jam_h), .accepted_cnt(accepted_cnt_h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive inputs, then return 1 time unit after the next rising edge
    task automatic step(input logic n, input logic d, input logic r);
        nickel_raw = n;
        dime_raw   = d;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    // one pulse of hi cycles then lo idle cycles; edges numbered from 1
    task automatic run_seq(input logic n, input logic d, input int hi, input int lo,
                           input bit use_h, output int ncodes, output int code,
                           output int cedge, output int jedge, output int viol);
        logic [1:0] c, prev;
        logic       j;
        ncodes = 0; code = 0; cedge = -1; jedge = -1; viol = 0; prev = 2'b00;
        for (int e = 1; e <= hi + lo; e++) begin
            step((e <= hi) ? n : 1'b0, (e <= hi) ? d : 1'b0, 1'b0);
            c = use_h ? coin_h : coin;
            j = use_h ? jam_h : jam;
            if (c != 2'b00) begin
                ncodes++;
                if (cedge < 0) begin
                    cedge = e;
                    code  = int'(c);
                end
            end
            if (c == 2'b11 || (c != 2'b00 && prev != 2'b00)) viol++;
            if (j && jedge < 0) jedge = e;
            prev = c;
        end
    endtask

    typedef struct {
        logic n;
        logic d;
        int   hi;
        int   lo;
        int   ncodes;
        int   code;
        int   cedge;
        int   jedge;
    } vec_t;

    vec_t vt[5];

    initial begin
        int         nc, cd, ce, je, vi;
        logic [7:0] cnt0, delta, mcnt;
        logic [1:0] prev, expc;

        vt[0] = '{1'b1, 1'b0, 20, 12, 1, 1, 7, -1};  // nickel pulse
        vt[1] = '{1'b0, 1'b1, 10, 12, 1, 2, 7, -1};  // dime pulse
        vt[2] = '{1'b1, 1'b1, 10, 12, 0, 0, -1, 7};  // simultaneous -> jam
        vt[3] = '{1'b1, 1'b0,  3, 12, 0, 0, -1, -1}; // glitch below DEBOUNCE
        vt[4] = '{1'b0, 1'b1,  4, 12, 1, 2, 7, -1};  // exactly DEBOUNCE cycles

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk("reset_coin", int'(coin), 0);
        chk("reset_jam", int'(jam), 0);
        chk("reset_cnt", int'(accepted_cnt), 0);
        chk("reset_coin_h", int'(coin_h), 0);
        chk("reset_cnt_h", int'(accepted_cnt_h), 0);
        step(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            cnt0 = accepted_cnt;
            run_seq(vt[i].n, vt[i].d, vt[i].hi, vt[i].lo, 1'b0, nc, cd, ce, je, vi);
            delta = accepted_cnt - cnt0;
            $display("vector %0d", i);
            chk("vec_ncodes", nc, vt[i].ncodes);
            chk("vec_code", cd, vt[i].code);
            chk("vec_code_edge", ce, vt[i].cedge);
            chk("vec_jam_edge", je, vt[i].jedge);
            chk("vec_viol", vi, 0);
            chk("vec_cnt_delta", int'(delta), vt[i].ncodes);
            chk("vec_end_jam", int'(jam), 0);
            chk("vec_end_coin", int'(coin), 0);
        end

        // bounce: 1,0,1,0,1,0 then 10 high -> one dime after edge 13
        nc = 0; ce = -1; cd = 0;
        for (int e = 1; e <= 28; e++) begin
            step(1'b0, (e <= 6) ? ((e % 2) == 1) : (e <= 16), 1'b0);
            if (coin != 2'b00) begin
                nc++;
                if (ce < 0) begin ce = e; cd = int'(coin); end
            end
        end
        chk("bounce_ncodes", nc, 1);
        chk("bounce_edge", ce, 13);
        chk("bounce_code", cd, 2);

        // stuck nickel on HOLD_MAX=16 instance, then a normal dime
        run_seq(1'b1, 1'b0, 40, 12, 1'b1, nc, cd, ce, je, vi);
        chk("stuck_ncodes", nc, 1);
        chk("stuck_code", cd, 1);
        chk("stuck_code_edge", ce, 7);
        chk("stuck_jam_edge", je, 23);
        chk("stuck_end_jam", int'(jam_h), 0);
        run_seq(1'b0, 1'b1, 8, 12, 1'b1, nc, cd, ce, je, vi);
        chk("after_stuck_ncodes", nc, 1);
        chk("after_stuck_code", cd, 2);
        chk("after_stuck_edge", ce, 7);
        chk("after_stuck_jam", je, -1);

        // reset at edge 5 of a held dime
        nc = 0; ce = -1; vi = 0;
        for (int e = 1; e <= 30; e++) begin
            step(1'b0, e <= 18, e == 5);
            if (e < 5 && coin != 2'b00) vi++;
            if (e == 5) begin
                chk("midrst_coin", int'(coin), 0);
                chk("midrst_jam", int'(jam), 0);
                chk("midrst_cnt", int'(accepted_cnt), 0);
                chk("midrst_cnt_h", int'(accepted_cnt_h), 0);
            end
            if (e > 5 && coin != 2'b00) begin
                nc++;
                if (ce < 0) ce = e;
            end
        end
        chk("midrst_early_code", vi, 0);
        chk("midrst_ncodes", nc, 1);
        chk("midrst_edge", ce, 12);

        // back-to-back alternating coins, 256 codes, counter wraps
        step(1'b0, 1'b0, 1'b1);
        chk("b2b_start_cnt", int'(accepted_cnt), 0);
        mcnt = 8'd0; nc = 0; vi = 0; prev = 2'b00;
        for (int k = 0; k < 256; k++) begin
            expc = ((k % 2) == 0) ? 2'b01 : 2'b10;
            for (int e = 1; e <= 16; e++) begin
                step((e <= 8) && expc[0], (e <= 8) && expc[1], 1'b0);
                if (coin != 2'b00) begin
                    nc++;
                    mcnt = mcnt + 8'd1;
                    chk("b2b_code", int'(coin), int'(expc));
                    chk("b2b_cnt", int'(accepted_cnt), int'(mcnt));
                    if (prev != 2'b00) vi++;
                end
                prev = coin;
            end
        end
        for (int e = 0; e < 4; e++) step(1'b0, 1'b0, 1'b0);
        chk("b2b_ncodes", nc, 256);
        chk("b2b_consecutive", vi, 0);
        chk("b2b_wrap_cnt", int'(accepted_cnt), 0);
        chk("b2b_end_jam", int'(jam), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage for the vending controller. It takes the two raw coin-slot sensor lines (nickel, dime), synchronises and debounces them, and emits one single-cycle coin code per physical coin on the 2-bit `coin` bus that the vending FSM consumes (01 = 5, 10 = 10, 00 = none). It also detects jams, meaning simultaneous or stuck sensors, and suppresses coin codes while jammed.

## Interface
- `DEBOUNCE`, default 4: consecutive cycles a synchronised line must differ from its filtered value before the filtered value flips (legal range 1..255).
- `HOLD_MAX`, default 1000: maximum cycles a single coin's filtered line may stay high before a jam is declared (legal range 1..65535).
- `clk` input, 1 bit: single clock, all state on rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `nickel_raw` input, 1 bit: raw nickel sensor, asynchronous, active-high.
- `dime_raw` input, 1 bit: raw dime sensor, asynchronous, active-high.
- `coin` output, 2 bits: registered; 01 for one cycle per accepted nickel, 10 for one cycle per accepted dime, else 00; 11 never driven.
- `jam` output, 1 bit: registered; high while in JAM state.
- `accepted_cnt` output, 8 bits: registered count of coin codes issued; wraps 255 -> 0.

## Operation
- Synchroniser: two flops per raw line (sync1, sync2), both reset to 0.
- Debounce, per line: 8-bit counter `dcnt` and filtered bit `filt`.
  - If sync2 == filt, dcnt <= 0.
  - Else, if dcnt == DEBOUNCE-1: filt toggles and dcnt <= 0.
  - Else: dcnt increments.
  - A rising edge of filt is a "rise" event for that line, visible the cycle after filt goes high.
- Control FSM has states IDLE, BUSY and JAM; it resets to IDLE.
- IDLE:
  - Nickel rise only: coin <= 01, go to BUSY.
  - Dime rise only: coin <= 10, go to BUSY.
  - Both rise in the same cycle, or one line rises while the other filt is already high: go to JAM, no code issued.
- BUSY:
  - The hold counter (16-bit, saturating) increments each cycle while in BUSY and clears on entry.
  - Both filt low: go to IDLE.
  - Rise on the other line: go to JAM.
  - Hold counter reaches HOLD_MAX: go to JAM.
- JAM:
  - jam = 1 and coin stays 00.
  - Both filt low: go to IDLE and clear jam.
  - Any rise seen in JAM is ignored and never replayed later.
- `coin` is non-zero for exactly one cycle per accepted coin. It is never asserted two cycles in a row, because a rise always leaves IDLE.
- `accepted_cnt` increments in the same cycle coin is non-zero.

## Timing
- All outputs reset to coin = 00, jam = 0, accepted_cnt = 0. Reset also clears sync, filt, dcnt, the hold counter and the FSM.
- Acceptance latency, with edge 1 being the first rising edge that samples raw high (raw steady thereafter):
  - sync2 = 1 after edge 2.
  - filt = 1 after edge DEBOUNCE+2.
  - coin valid after edge DEBOUNCE+3, for one cycle.
  - With DEBOUNCE = 4, coin is valid after edge 7.
- Release latency: filt falls DEBOUNCE+2 edges after raw is first sampled low.
- Glitches shorter than DEBOUNCE synchronised cycles never flip filt and produce no code.
- Jam entry is registered: jam rises in the cycle after the offending event. Jam exit is registered the same way.
- Reset mid-operation discards any in-flight coin. A raw line still high when reset deasserts is treated as a new coin and accepted after the normal latency.
- accepted_cnt wrap: 255 + 1 = 0 with no flag.

## Test plan
- Nickel pulse, DEBOUNCE = 4: nickel_raw high for 20 cycles, then low -> coin = 01 for exactly one cycle after edge 7, accepted_cnt = 1, jam = 0, FSM back in IDLE after release.
- Bounce filter: dime_raw toggles 1,0,1,0,1,0 one cycle each, then high for 10 cycles -> exactly one coin = 10, and the 1-cycle pulses alone produce no code.
- Simultaneous sensors: both raw lines rise on the same edge and stay high for 10 cycles -> coin stays 00, jam = 1 from the cycle after both filt rise; both low -> jam = 0 after release latency, accepted_cnt = 0.
- Stuck coin, HOLD_MAX = 16: nickel_raw held high for 40 cycles -> one coin = 01, jam rises 16 cycles after BUSY entry; release -> IDLE; a following dime is accepted normally as 10.
- Back-to-back coins: nickel, then dime (each high for 8 cycles, separated by 8 low cycles), repeated 128 times -> 256 alternating single-cycle codes; accepted_cnt wraps to 0.
- Reset mid-coin: assert rst for 1 cycle at edge 5 of a held dime -> no code before reset; after deassert, coin = 10 exactly DEBOUNCE+3 edges later, with all outputs 0 during reset.
